// File: rtl/alu_sequencer.sv
// alu_sequencer: buffers 16-bit instruction words in a small FIFO and turns
// them into registered ALU commands, one per cycle. LOADI takes two FIFO
// words: the opcode word and then the immediate it loads.
// Build option: `define ALU_SEQ_TRAP_EN compiles in the overflow trap. A rising
// alu_overflow then parks the sequencer in HALT until clear_trap. Without the
// macro, trap is tied low and the overflow/clear inputs are ignored.
//
// Handshake: a word is taken on a rising CLK edge where instr_valid && instr_ready.
// instr_ready depends only on the FIFO fill level. It never follows instr_valid
// combinationally, and a full FIFO refuses a word even in a cycle that pops.
module alu_sequencer #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        instr_valid,
    input  logic [15:0] instr_data,
    output logic        instr_ready,
    input  logic        flush,
    output logic [5:0]  alu_operation,
    output logic [2:0]  alu_op1_idx,
    output logic [2:0]  alu_op2_idx,
    output logic [2:0]  alu_res_idx,
    output logic [3:0]  alu_params,
    output logic        alu_read_bus,
    output logic [15:0] alu_din,
    input  logic        alu_overflow,
    output logic        busy,
    output logic [15:0] issue_count,
    output logic        trap,
    input  logic        clear_trap,
    output logic [1:0]  dbg_state
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] ONE_CNT  = CW'(1);

    localparam logic [2:0] CL_LOADI = 3'd6;
    localparam logic [5:0] OP_LOAD  = 6'b100000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        IMM   = 2'd2,
        HALT  = 2'd3
    } state_t;

    // Class field to ALU operation; NOP, LOADI and reserved map to zero here.
    function automatic logic [5:0] class_to_op(input logic [2:0] cls);
        case (cls)
            3'd1:    class_to_op = 6'b100001;
            3'd2:    class_to_op = 6'b100010;
            3'd3:    class_to_op = 6'b100100;
            3'd4:    class_to_op = 6'b101000;
            3'd5:    class_to_op = 6'b110000;
            default: class_to_op = 6'b000000;
        endcase
    endfunction

    state_t        state_q, state_d;
    logic [15:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          push, pop, last_word, kill;
    logic [15:0]   head;
    logic [5:0]    head_op;
    logic [2:0]    ldi_dst_q, ldi_dst_d;

    logic [5:0]    op_q, op_d;
    logic [2:0]    op1_q, op1_d;
    logic [2:0]    op2_q, op2_d;
    logic [2:0]    res_q, res_d;
    logic [3:0]    params_q, params_d;
    logic          rb_q, rb_d;
    logic [15:0]   din_q, din_d;
    logic          cnt_inc;
    logic [15:0]   issue_count_q;

    logic          ovf_rise, trap_clear, ldi_pend;

`ifdef ALU_SEQ_TRAP_EN
    logic ovf_q, trap_q, ldi_pend_q;

    assign ovf_rise   = alu_overflow && !ovf_q;
    assign trap_clear = clear_trap;
    assign ldi_pend   = ldi_pend_q;
    assign trap       = trap_q;

    // Overflow edge detect, sticky trap flag, and memory of a LOADI parked by HALT
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ovf_q      <= 1'b0;
            trap_q     <= 1'b0;
            ldi_pend_q <= 1'b0;
        end else begin
            ovf_q <= alu_overflow;
            if (ovf_rise) begin
                trap_q <= 1'b1;
            end else if (clear_trap) begin
                trap_q <= 1'b0;
            end
            if (flush) begin
                ldi_pend_q <= 1'b0;
            end else if (ovf_rise && (state_q != HALT)) begin
                ldi_pend_q <= (state_q == IMM);
            end
        end
    end
`else
    logic unused_trap_inputs;

    assign unused_trap_inputs = alu_overflow ^ clear_trap;
    assign ovf_rise   = 1'b0;
    assign trap_clear = 1'b0;
    assign ldi_pend   = 1'b0;
    assign trap       = 1'b0;
`endif

    assign instr_ready = (count_q != FULL_CNT);
    assign push        = instr_valid && instr_ready;
    assign head        = mem_q[rd_ptr_q];
    assign head_op     = class_to_op(head[15:13]);
    // Popping this word empties the FIFO unless a new word arrives on the same edge.
    assign last_word   = (count_q == ONE_CNT) && !push;
    // flush and a new overflow trap both suppress this cycle's pop and command.
    assign kill        = flush || ovf_rise;

    // FIFO storage write; entries past the read pointer are don't-care, so no reset
    always_ff @(posedge CLK) begin
        if (push && !flush) begin
            mem_q[wr_ptr_q] <= instr_data;
        end
    end

    // FIFO pointers and fill level; flush empties it regardless of push/pop
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    // Next state, pop decision and next ALU command
    always_comb begin
        state_d   = state_q;
        ldi_dst_d = ldi_dst_q;
        pop       = 1'b0;
        cnt_inc   = 1'b0;
        op_d      = '0;
        op1_d     = '0;
        op2_d     = '0;
        res_d     = '0;
        params_d  = '0;
        rb_d      = 1'b0;
        din_d     = '0;

        unique case (state_q)
            IDLE: begin
                // A word pushed this cycle is only visible next cycle.
                if (count_q != '0) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (count_q == '0) begin
                    state_d = IDLE;
                end else begin
                    pop     = 1'b1;
                    state_d = last_word ? IDLE : ISSUE;
                    if (head[15:13] == CL_LOADI) begin
                        ldi_dst_d = head[12:10];
                        state_d   = IMM;
                    end else if (head_op != '0) begin
                        op_d     = head_op;
                        op1_d    = head[9:7];
                        op2_d    = head[6:4];
                        res_d    = head[12:10];
                        params_d = head[3:0];
                        cnt_inc  = 1'b1;
                    end
                end
            end
            IMM: begin
                // The next word is the immediate. Wait here while the FIFO is empty.
                if (count_q != '0) begin
                    pop     = 1'b1;
                    op_d    = OP_LOAD;
                    rb_d    = 1'b1;
                    din_d   = head;
                    res_d   = ldi_dst_q;
                    cnt_inc = 1'b1;
                    state_d = last_word ? IDLE : ISSUE;
                end
            end
            HALT: begin
                if (trap_clear) begin
                    if (ldi_pend) begin
                        state_d = IMM;
                    end else if (count_q != '0) begin
                        state_d = ISSUE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (kill) begin
            pop       = 1'b0;
            cnt_inc   = 1'b0;
            ldi_dst_d = ldi_dst_q;
            op_d      = '0;
            op1_d     = '0;
            op2_d     = '0;
            res_d     = '0;
            params_d  = '0;
            rb_d      = 1'b0;
            din_d     = '0;
            // A new trap outranks flush for the state; the trap flag survives flush anyway.
            state_d   = ovf_rise ? HALT : IDLE;
        end
    end

    // FSM state and the destination of the LOADI awaiting its immediate
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= IDLE;
            ldi_dst_q <= '0;
        end else begin
            state_q   <= state_d;
            ldi_dst_q <= ldi_dst_d;
        end
    end

    // Registered ALU command port (zero outside issue cycles) and issue counter
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            op_q          <= '0;
            op1_q         <= '0;
            op2_q         <= '0;
            res_q         <= '0;
            params_q      <= '0;
            rb_q          <= 1'b0;
            din_q         <= '0;
            issue_count_q <= '0;
        end else begin
            op_q     <= op_d;
            op1_q    <= op1_d;
            op2_q    <= op2_d;
            res_q    <= res_d;
            params_q <= params_d;
            rb_q     <= rb_d;
            din_q    <= din_d;
            if (cnt_inc) begin
                issue_count_q <= issue_count_q + 16'd1;
            end
        end
    end

    assign alu_operation = op_q;
    assign alu_op1_idx   = op1_q;
    assign alu_op2_idx   = op2_q;
    assign alu_res_idx   = res_q;
    assign alu_params    = params_q;
    assign alu_read_bus  = rb_q;
    assign alu_din       = din_q;
    assign issue_count   = issue_count_q;
    assign busy          = (count_q != '0) || (state_q != IDLE);
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed and randomized checks of alu_sequencer.
// The reference model turns the accepted word stream into the ordered list of
// ALU commands it must produce. Timing is checked by the directed steps.
module tb_alu_sequencer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        instr_valid = 1'b0;
    logic [15:0] instr_data = 16'h0;
    logic        flush = 1'b0;
    logic        alu_overflow = 1'b0;
    logic        clear_trap = 1'b0;
    logic        instr_ready;
    logic [5:0]  alu_operation;
    logic [2:0]  alu_op1_idx, alu_op2_idx, alu_res_idx;
    logic [3:0]  alu_params;
    logic        alu_read_bus;
    logic [15:0] alu_din;
    logic        busy;
    logic [15:0] issue_count;
    logic        trap;
    logic [1:0]  dbg_state;

    int tests = 0;
    int fails = 0;
    logic [35:0] exp_q[$];
    logic [35:0] got_q[$];
    logic [15:0] words[$];
    bit          mon_en = 1'b0;

    alu_sequencer #(.FIFO_DEPTH(DEPTH)) dut (
        .CLK          (clk),
        .RST_N        (rst_n),
        .instr_valid  (instr_valid),
        .instr_data   (instr_data),
        .instr_ready  (instr_ready),
        .flush        (flush),
        .alu_operation(alu_operation),
        .alu_op1_idx  (alu_op1_idx),
        .alu_op2_idx  (alu_op2_idx),
        .alu_res_idx  (alu_res_idx),
        .alu_params   (alu_params),
        .alu_read_bus (alu_read_bus),
        .alu_din      (alu_din),
        .alu_overflow (alu_overflow),
        .busy         (busy),
        .issue_count  (issue_count),
        .trap         (trap),
        .clear_trap   (clear_trap),
        .dbg_state    (dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #1000000;
        $display("FAIL watchdog: observed still running, required finished");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [35:0] cmd(input logic [5:0] op, input logic [2:0] a,
                                        input logic [2:0] b, input logic [2:0] r,
                                        input logic [3:0] p, input logic rb,
                                        input logic [15:0] d);
        return {op, a, b, r, p, rb, d};
    endfunction

    function automatic logic [35:0] obs_cmd();
        return cmd(alu_operation, alu_op1_idx, alu_op2_idx, alu_res_idx,
                   alu_params, alu_read_bus, alu_din);
    endfunction

    // Operation codes straight from the class table
    function automatic logic [5:0] class_op(input logic [2:0] c);
        case (c)
            3'd1:    return 6'h21;
            3'd2:    return 6'h22;
            3'd3:    return 6'h24;
            3'd4:    return 6'h28;
            3'd5:    return 6'h30;
            default: return 6'h00;
        endcase
    endfunction

    // Reference model: accepted words -> ordered expected ALU commands
    task automatic build_exp(output bit pend);
        logic [2:0]  pdst;
        logic [15:0] w;
        logic [2:0]  c;
        pend = 1'b0;
        pdst = 3'd0;
        exp_q.delete();
        foreach (words[i]) begin
            w = words[i];
            c = w[15:13];
            if (pend) begin
                exp_q.push_back(cmd(6'h20, 3'd0, 3'd0, pdst, 4'd0, 1'b1, w));
                pend = 1'b0;
            end else if (c == 3'd6) begin
                pend = 1'b1;
                pdst = w[12:10];
            end else if (class_op(c) != 6'h00) begin
                exp_q.push_back(cmd(class_op(c), w[9:7], w[6:4], w[12:10], w[3:0], 1'b0, 16'h0));
            end
        end
    endtask

    task automatic check(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one word and hold it until accepted (bounded)
    task automatic push_word(input logic [15:0] w);
        int n;
        n = 0;
        instr_valid = 1'b1;
        instr_data  = w;
        while (!instr_ready && n < 50) begin
            tick();
            n++;
        end
        check("push_ready_timeout", 36'(instr_ready), 36'(1));
        tick();
        instr_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 200) begin
            tick();
            n++;
        end
        check({tag, "_idle_timeout"}, 36'(busy), 36'(0));
        tick();
        tick();
    endtask

    task automatic compare_stream(input string tag);
        check({tag, "_len"}, 36'(got_q.size()), 36'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check(tag, got_q[i], exp_q[i]);
        end
    endtask

    // Monitor: collect every ALU command, sampled mid-cycle
    always @(negedge clk) begin
        if (mon_en && alu_operation != 6'h00) begin
            got_q.push_back(obs_cmd());
        end
    end

    initial begin
        logic [15:0] exp_cnt;
        bit          pend;
        bit          acc;
        int          n;

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 36'(instr_ready), 36'(1));
        check("rst_busy", 36'(busy), 36'(0));
        check("rst_count", 36'(issue_count), 36'(0));
        check("rst_trap", 36'(trap), 36'(0));
        check("rst_cmd", obs_cmd(), 36'(0));
        rst_n = 1'b1;
        exp_cnt = 16'h0;
        tick();

        // Single ADDSUB: dst2 src1 src3 p1, command two cycles after acceptance
        push_word(16'h28B1);
        check("lat_n0", 36'(alu_operation), 36'(0));
        tick();
        check("lat_n1", 36'(alu_operation), 36'(0));
        tick();
        check("addsub_cmd", obs_cmd(), cmd(6'h21, 3'd1, 3'd3, 3'd2, 4'd1, 1'b0, 16'h0));
        exp_cnt = exp_cnt + 16'd1;
        check("addsub_count", 36'(issue_count), 36'(exp_cnt));
        tick();
        check("addsub_one_cycle", 36'(alu_operation), 36'(0));
        check("addsub_idle", 36'(busy), 36'(0));

        // 0x2A31 decodes to dst2 src1=4 src2=3 p1
        push_word(16'h2A31);
        tick();
        tick();
        check("addsub2_cmd", obs_cmd(), cmd(6'h21, 3'd4, 3'd3, 3'd2, 4'd1, 1'b0, 16'h0));
        exp_cnt = exp_cnt + 16'd1;
        tick();

        // LOADI 0xC400 (dst1), immediate 0xBEEF offered after a gap
        push_word(16'hC400);
        check("ldi_gap0", 36'(alu_operation), 36'(0));
        for (int i = 0; i < 3; i++) begin
            tick();
            check("ldi_gap", {30'd0, alu_operation}, 36'(0));
            check("ldi_gap_rb", 36'(alu_read_bus), 36'(0));
        end
        push_word(16'hBEEF);
        check("ldi_pre", 36'(alu_operation), 36'(0));
        tick();
        check("ldi_cmd", obs_cmd(), cmd(6'h20, 3'd0, 3'd0, 3'd1, 4'd0, 1'b1, 16'hBEEF));
        exp_cnt = exp_cnt + 16'd1;
        check("ldi_count", 36'(issue_count), 36'(exp_cnt));
        tick();
        check("ldi_rb_drop", 36'(alu_read_bus), 36'(0));
        check("ldi_idle", 36'(busy), 36'(0));

        // Flush while LOADI waits for its immediate, with a simultaneous push
        push_word(16'hC400);
        tick();
        tick();
        flush = 1'b1;
        instr_valid = 1'b1;
        instr_data = 16'hBEEF;
        tick();
        flush = 1'b0;
        instr_valid = 1'b0;
        check("flush_imm_busy", 36'(busy), 36'(0));
        check("flush_imm_cmd", obs_cmd(), 36'(0));
        check("flush_imm_ready", 36'(instr_ready), 36'(1));
        tick();
        check("flush_imm_cmd2", 36'(alu_operation), 36'(0));
        push_word(16'h28B1);
        tick();
        tick();
        check("flush_imm_after", obs_cmd(), cmd(6'h21, 3'd1, 3'd3, 3'd2, 4'd1, 1'b0, 16'h0));
        exp_cnt = exp_cnt + 16'd1;
        tick();

        // Flush with queued words: only the first word issues
        instr_valid = 1'b1;
        instr_data = 16'h28B1;
        tick();
        instr_data = 16'h4C52;
        tick();
        instr_data = 16'h6C73;
        tick();
        check("flushq_first", 36'(alu_operation), 36'(6'h21));
        exp_cnt = exp_cnt + 16'd1;
        instr_valid = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flushq_cmd", 36'(alu_operation), 36'(0));
        check("flushq_busy", 36'(busy), 36'(0));
        check("flushq_ready", 36'(instr_ready), 36'(1));
        tick();
        check("flushq_cmd2", 36'(alu_operation), 36'(0));
        check("flushq_count", 36'(issue_count), 36'(exp_cnt));

`ifndef ALU_SEQ_TRAP_EN
        // Without the trap build, overflow and clear_trap do nothing
        alu_overflow = 1'b1;
        clear_trap = 1'b1;
        push_word(16'h28B1);
        clear_trap = 1'b0;
        tick();
        check("notrap_trap", 36'(trap), 36'(0));
        tick();
        check("notrap_cmd", obs_cmd(), cmd(6'h21, 3'd1, 3'd3, 3'd2, 4'd1, 1'b0, 16'h0));
        exp_cnt = exp_cnt + 16'd1;
        alu_overflow = 1'b0;
        tick();
`endif

        // Randomized stream against the reference model
        words.delete();
        got_q.delete();
        mon_en = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) != 0) begin
                instr_valid = 1'b1;
                instr_data = 16'($urandom);
            end else begin
                instr_valid = 1'b0;
            end
`ifndef ALU_SEQ_TRAP_EN
            alu_overflow = 1'($urandom_range(0, 1));
            clear_trap = 1'($urandom_range(0, 1));
`endif
            acc = instr_valid && instr_ready;
            tick();
            if (acc) words.push_back(instr_data);
`ifndef ALU_SEQ_TRAP_EN
            check("rand_trap_low", 36'(trap), 36'(0));
`endif
        end
        instr_valid = 1'b0;
        alu_overflow = 1'b0;
        clear_trap = 1'b0;
        build_exp(pend);
        if (pend) begin
            push_word(16'h1234);
            words.push_back(16'h1234);
        end
        wait_idle("rand");
        mon_en = 1'b0;
        build_exp(pend);
        compare_stream("rand_cmd");
        exp_cnt = exp_cnt + 16'(exp_q.size());
        check("rand_count", 36'(issue_count), 36'(exp_cnt));

`ifdef ALU_SEQ_TRAP_EN
        // MUL stream with an overflow edge: issue halts, FIFO fills, clear resumes
        words.delete();
        got_q.delete();
        mon_en = 1'b1;
        for (int c = 0; c < 10; c++) begin
            instr_valid = 1'b1;
            instr_data = {3'd2, 3'(c), 3'(c + 1), 3'(c + 2), 4'(c)};
            if (c == 3) alu_overflow = 1'b1;
            acc = instr_ready;
            tick();
            if (acc) words.push_back(instr_data);
            if (c >= 3) begin
                check("halt_trap", 36'(trap), 36'(1));
                check("halt_no_issue", 36'(alu_operation), 36'(0));
            end
        end
        check("halt_full_ready", 36'(instr_ready), 36'(0));
        check("halt_busy", 36'(busy), 36'(1));
        check("halt_accepts", 36'(words.size()), 36'(DEPTH + 1));
        instr_valid = 1'b0;
        clear_trap = 1'b1;
        tick();
        clear_trap = 1'b0;
        check("halt_cleared", 36'(trap), 36'(0));
        wait_idle("halt");
        mon_en = 1'b0;
        build_exp(pend);
        compare_stream("halt_cmd");
        exp_cnt = exp_cnt + 16'(exp_q.size());
        check("halt_count", 36'(issue_count), 36'(exp_cnt));
        alu_overflow = 1'b0;
        tick();
`endif

        // Asynchronous reset while a LOADI command is on the ALU port
        instr_valid = 1'b1;
        instr_data = 16'hC400;
        tick();
        instr_data = 16'hBEEF;
        tick();
        instr_valid = 1'b0;
        n = 0;
        while (alu_operation !== 6'h20 && n < 10) begin
            tick();
            n++;
        end
        check("arst_wait_loadi", 36'(alu_operation), 36'(6'h20));
        #3 rst_n = 1'b0;
        #1;
        check("arst_cmd", obs_cmd(), 36'(0));
        check("arst_count", 36'(issue_count), 36'(0));
        check("arst_busy", 36'(busy), 36'(0));
        check("arst_ready", 36'(instr_ready), 36'(1));
        check("arst_trap", 36'(trap), 36'(0));
        #2 rst_n = 1'b1;
        tick();

        // Reset while LOADI waits: the next word is an instruction, not an immediate
        push_word(16'hC400);
        tick();
        tick();
        #3 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        tick();
        push_word(16'h28B1);
        tick();
        tick();
        check("rst_ldi_discard", obs_cmd(), cmd(6'h21, 3'd1, 3'd3, 3'd2, 4'd1, 1'b0, 16'h0));
        check("rst_ldi_count", 36'(issue_count), 36'(1));
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
